jt89_gain_mixer: RTL and testbench



---
 rtl/jt89_gain_mixer.sv | 161 ++++++++++++++++
 tb/tb_jt89_gain_mixer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/jt89_gain_mixer.sv
// jt89_gain_mixer: time-multiplexed N-channel PSG mixer with per-channel gain and mute.
// Optional DC blocker before saturation: define JT89_MIXER_DCBLOCK_EN.
module jt89_gain_mixer #(
    parameter int bw       = 9,
    parameter int chn      = 4,
    parameter int gw       = 4,
    parameter int ow       = bw + 2,
    parameter int dc_shift = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 cen_16,
    input  logic [chn*bw-1:0]    ch,
    input  logic [chn*gw-1:0]    gain,
    input  logic [chn-1:0]       mute,
    output logic [ow-1:0]        sound,
    output logic                 sample_vld,
    output logic                 busy
);

    localparam int iw = $clog2(chn);
    localparam int pw = bw + gw + 1;
    localparam int aw = bw + gw + $clog2(chn) + 1;
`ifdef JT89_MIXER_DCBLOCK_EN
    localparam int sw = aw + 2;
`else
    localparam int sw = aw;
`endif

    localparam logic signed [sw-1:0] smax =
        {{(sw-ow+1){1'b0}}, {(ow-1){1'b1}}};
    localparam logic signed [sw-1:0] smin =
        {{(sw-ow+1){1'b1}}, {(ow-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t state, state_nx;

    logic [chn*bw-1:0]      ch_s;
    logic [chn*gw-1:0]      gain_s;
    logic [chn-1:0]         mute_s;
    logic [iw-1:0]          idx;
    logic signed [aw-1:0]   acc;

    logic signed [bw-1:0]   ch_i;
    logic [gw-1:0]          g_i;
    logic signed [pw-1:0]   prod;
    logic signed [pw-1:0]   term;
    logic signed [aw-1:0]   term_x;
    logic signed [sw-1:0]   mix_val;

    function automatic logic [ow-1:0] sat(input logic signed [sw-1:0] v);
        if (v > smax)
            return smax[ow-1:0];
        else if (v < smin)
            return smin[ow-1:0];
        else
            return v[ow-1:0];
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; every transition waits for an enabled cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (clk_en && cen_16) state_nx = ACC;
            ACC:  if (clk_en && idx == iw'(chn-1)) state_nx = OUT;
            OUT:  if (clk_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: busy covers the accumulation phase only
    always_comb begin
        busy = (state == ACC);
    end

    // Scaled contribution of the channel currently selected by idx
    always_comb begin
        ch_i   = ch_s[idx*bw +: bw];
        g_i    = gain_s[idx*gw +: gw];
        prod   = pw'(ch_i) * pw'($signed({1'b0, g_i}));
        term   = prod >>> (gw - 2);
        if (mute_s[idx])
            term = '0;
        term_x = {{(aw-pw){term[pw-1]}}, term};
    end

`ifdef JT89_MIXER_DCBLOCK_EN
    logic signed [sw-1:0] acc_x;
    logic signed [sw-1:0] x_prev;
    logic signed [sw-1:0] y_prev;
    logic signed [sw-1:0] y_nx;

    // First-order high-pass applied to the finished sum
    always_comb begin
        acc_x   = {{2{acc[aw-1]}}, acc};
        y_nx    = acc_x - x_prev + y_prev - (y_prev >>> dc_shift);
        mix_val = y_nx;
    end

    // DC blocker history, updated once per output sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (clk_en && state == OUT) begin
            x_prev <= acc_x;
            y_prev <= y_nx;
        end
    end
`else
    assign mix_val = acc;
`endif

    // Snapshot, serial accumulation and registered saturated output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_s       <= '0;
            gain_s     <= '0;
            mute_s     <= '0;
            idx        <= '0;
            acc        <= '0;
            sound      <= '0;
            sample_vld <= 1'b0;
        end else begin
            sample_vld <= 1'b0;
            if (clk_en) begin
                unique case (state)
                    IDLE: begin
                        if (cen_16) begin
                            ch_s   <= ch;
                            gain_s <= gain;
                            mute_s <= mute;
                            idx    <= '0;
                            acc    <= '0;
                        end
                    end
                    ACC: begin
                        acc <= acc + term_x;
                        idx <= idx + 1'b1;
                    end
                    OUT: begin
                        sound      <= sat(mix_val);
                        sample_vld <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt89_gain_mixer.sv
// tb_jt89_gain_mixer: directed vectors for jt89_gain_mixer (bw=9, chn=4, gw=4, ow=11).
// Define JT89_MIXER_DCBLOCK_EN to run the DC-blocker vectors instead.
module tb_jt89_gain_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        cen_16 = 1'b0;
    logic [35:0] ch = '0;
    logic [15:0] gain = '0;
    logic [3:0]  mute = '0;
    logic [10:0] sound;
    logic        sample_vld;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int busy_n;

    always #5 clk = ~clk;

    jt89_gain_mixer dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .cen_16     (cen_16),
        .ch         (ch),
        .gain       (gain),
        .mute       (mute),
        .sound      (sound),
        .sample_vld (sample_vld),
        .busy       (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int c0, c1, c2, c3,
                        input int g0, g1, g2, g3,
                        input logic [3:0] m);
        ch   = {9'(c3), 9'(c2), 9'(c1), 9'(c0)};
        gain = {4'(g3), 4'(g2), 4'(g1), 4'(g0)};
        mute = m;
    endtask

    function automatic int snd();
        return int'($signed(sound));
    endfunction

    // Called at posedge+1; strobes, waits for sample_vld, checks result.
    task automatic run_mix(input string tag, input int exp);
        int n;
        cen_16 = 1'b1;
        @(posedge clk);
        #1;
        cen_16 = 1'b0;
        busy_n = int'(busy);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (sample_vld) break;
            busy_n += int'(busy);
        end
        chk({tag, "_lat"}, n, 5);
        chk(tag, snd(), exp);
        @(posedge clk);
        #1;
        chk({tag, "_vldw"}, int'(sample_vld), 0);
    endtask

    initial begin
        int n;
        int v;
        #2;
        chk("rst_sound", snd(), 0);
        chk("rst_vld", int'(sample_vld), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef JT89_MIXER_DCBLOCK_EN
        load(100, 100, 100, 100, 4, 4, 4, 4, 4'b0000);
        run_mix("dc_first", 400);
        run_mix("dc_second", 394);
        run_mix("dc_third", 388);
`else
        load(100, 100, 100, 100, 4, 4, 4, 4, 4'b0000);
        run_mix("unity", 400);
        chk("unity_busy", busy_n, 4);

        load(255, 255, 255, 255, 15, 15, 15, 15, 4'b0000);
        run_mix("sat_pos", 1023);
        load(-256, -256, -256, -256, 15, 15, 15, 15, 4'b0000);
        run_mix("sat_neg", -1024);

        load(100, -50, 200, 7, 4, 8, 2, 0, 4'b0100);
        run_mix("mute_mix", 0);
        load(100, -50, 200, 7, 4, 8, 2, 0, 4'b0000);
        run_mix("gain_mix", 100);

        // second strobe two clocks into the sequence must be ignored
        load(10, 20, 30, 40, 4, 4, 4, 4, 4'b0000);
        cen_16 = 1'b1;
        @(posedge clk);
        #1;
        cen_16 = 1'b0;
        v = 0;
        @(posedge clk);
        #1;
        cen_16 = 1'b1;
        load(200, 200, 200, 200, 8, 8, 8, 8, 4'b0000);
        v += int'(sample_vld);
        @(posedge clk);
        #1;
        cen_16 = 1'b0;
        v += int'(sample_vld);
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            v += int'(sample_vld);
        end
        chk("overlap_vlds", v, 1);
        chk("overlap_sound", snd(), 100);

        // clk_en alternating; inputs change right after the strobe
        load(1, 2, 3, 4, 4, 4, 4, 4, 4'b0000);
        cen_16 = 1'b1;
        @(posedge clk);
        #1;
        cen_16 = 1'b0;
        clk_en = 1'b0;
        load(100, 100, 100, 100, 15, 15, 15, 15, 4'b0000);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            clk_en = ~clk_en;
            if (sample_vld) break;
        end
        chk("cen_lat", n, 10);
        chk("cen_sound", snd(), 10);
        clk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        chk("hold_sound", snd(), 10);

        // reset while idx=2 aborts the sequence
        load(100, 100, 100, 100, 4, 4, 4, 4, 4'b0000);
        cen_16 = 1'b1;
        @(posedge clk);
        #1;
        cen_16 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_sound", snd(), 0);
        chk("abort_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        v = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            v += int'(sample_vld);
        end
        chk("abort_novld", v, 0);
        run_mix("after_rst", 400);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
